// File: rtl/piezo_tone_seq_pkg.sv
// -----------------------------------------------------------------------------
// piezo_tone_seq_pkg
// Shared constants, sequencer state encoding and a digit-slot helper for the
// piezo tone sequencer and anything else that handles 4-digit BCD words.
// -----------------------------------------------------------------------------
package piezo_tone_seq_pkg;

  localparam int NUM_TONES = 10;  // one tone per decimal digit
  localparam int SEQ_LEN   = 4;   // digits in a guess/answer word
  localparam int BCD_W     = 4;   // bits per BCD digit
  localparam int IDX_W     = $clog2(SEQ_LEN);
  localparam int WORD_W    = SEQ_LEN * BCD_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Slot 0 is the most significant digit, so a word plays left to right.
  function automatic logic [BCD_W-1:0] digit_at(input logic [WORD_W-1:0] digits,
                                                input logic [IDX_W-1:0]  idx);
    int unsigned slot;
    slot = SEQ_LEN - 1 - int'(idx);
    return digits[slot*BCD_W +: BCD_W];
  endfunction

endpackage

// File: rtl/piezo_tone_seq_if.sv
// -----------------------------------------------------------------------------
// piezo_tone_seq_if
// Request/status bundle between the game controller (master) and the tone
// sequencer (slave).
//   key_valid / key_digit     : single-key beep request
//   play_start / play_digits  : 4-digit playback request, [15:12] first
//   abort                     : synchronous stop
//   tone_en                   : one-hot tone enables to the tone dividers
//   busy / done               : sequencer status, done is a 1-cycle pulse
// -----------------------------------------------------------------------------
interface piezo_tone_seq_if;
  import piezo_tone_seq_pkg::*;

  logic                 key_valid;
  logic [BCD_W-1:0]     key_digit;
  logic                 play_start;
  logic [WORD_W-1:0]    play_digits;
  logic                 abort;
  logic [NUM_TONES-1:0] tone_en;
  logic                 busy;
  logic                 done;

  modport master (
    output key_valid, key_digit, play_start, play_digits, abort,
    input  tone_en, busy, done
  );

  modport slave (
    input  key_valid, key_digit, play_start, play_digits, abort,
    output tone_en, busy, done
  );

endinterface

// File: rtl/piezo_tone_seq_bcd_onehot_dec.sv
// -----------------------------------------------------------------------------
// piezo_tone_seq_bcd_onehot_dec
// BCD digit to one-hot decoder. Codes 10..15 are not digits and decode to all
// zeros, so a corrupt slot can never light an LED or sound a tone.
//   code   : 4-bit BCD input
//   onehot : bit k set when code == k (k = 0..9)
// -----------------------------------------------------------------------------
module piezo_tone_seq_bcd_onehot_dec
  import piezo_tone_seq_pkg::*;
(
  input  logic [BCD_W-1:0]     code,
  output logic [NUM_TONES-1:0] onehot
);

  always_comb begin
    for (int k = 0; k < NUM_TONES; k++) begin
      onehot[k] = (code == BCD_W'(k));
    end
  end

endmodule

// File: rtl/piezo_tone_seq.sv
// -----------------------------------------------------------------------------
// piezo_tone_seq
// Turns game events into per-digit tone enables for the piezo tone bank.
// A beep is a 1-digit sequence; a playback is 4 digits with silent gaps
// between them. tone_en comes straight from a register and is one-hot or zero.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : request/status bundle (slave side), see piezo_tone_seq_if
// Parameters:
//   TONE_CYCLES : cycles each digit tone is held (>= 1)
//   GAP_CYCLES  : cycles of silence between playback digits (>= 1)
//   CNT_W       : duration counter width, 2**CNT_W > max(TONE/GAP_CYCLES)
// -----------------------------------------------------------------------------
module piezo_tone_seq
  import piezo_tone_seq_pkg::*;
#(
  parameter int TONE_CYCLES = 200000,
  parameter int GAP_CYCLES  = 50000,
  parameter int CNT_W       = 18
) (
  input  logic              clk,
  input  logic              rst,
  piezo_tone_seq_if.slave   bus
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;     // index of the final slot
  logic [WORD_W-1:0]    digits_q, digits_d;
  logic [NUM_TONES-1:0] tone_en_q, tone_en_d;
  logic                 done_q, done_d;
  logic [NUM_TONES-1:0] next_onehot;
  logic                 tone_end, gap_end;

  assign tone_end = (cnt_q == CNT_W'(TONE_CYCLES - 1));
  assign gap_end  = (cnt_q == CNT_W'(GAP_CYCLES - 1));

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    last_d   = last_q;
    digits_d = digits_q;
    done_d   = 1'b0;

    if (bus.abort) begin
      // Wins over everything, including a start strobe in the same cycle.
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.play_start) begin
            digits_d = bus.play_digits;
            last_d   = IDX_W'(SEQ_LEN - 1);
            idx_d    = '0;
            state_d  = TONE;
          end else if (bus.key_valid) begin
            // A beep is a playback whose only slot is slot 0.
            digits_d = {bus.key_digit, {(WORD_W - BCD_W){1'b0}}};
            last_d   = '0;
            idx_d    = '0;
            state_d  = TONE;
          end
        end
        TONE: begin
          if (tone_end) begin
            if (idx_q == last_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = GAP;
            end
          end
        end
        GAP: begin
          if (gap_end) begin
            idx_d   = idx_q + 1'b1;
            state_d = TONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Restart timing on every state entry; IDLE keeps the counter parked.
    if ((state_d != state_q) || (state_q == IDLE)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Decode the slot that will be current next cycle so tone_en can be
  // registered and line up exactly with the TONE state.
  piezo_tone_seq_bcd_onehot_dec u_dec (
    .code   (digit_at(digits_d, idx_d)),
    .onehot (next_onehot)
  );

  assign tone_en_d = (state_d == TONE) ? next_onehot : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      digits_q  <= '0;
      tone_en_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      digits_q  <= digits_d;
      tone_en_q <= tone_en_d;
      done_q    <= done_d;
    end
  end

  assign bus.tone_en = tone_en_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_piezo_tone_seq.sv
// -----------------------------------------------------------------------------
// tb_piezo_tone_seq
// Self-checking bench for piezo_tone_seq with TONE_CYCLES=4, GAP_CYCLES=2.
// Each request pushes its expected per-cycle {tone_en, busy, done} trace onto
// a queue; a negedge monitor pops and compares one entry per cycle.
// -----------------------------------------------------------------------------
module tb_piezo_tone_seq;
  import piezo_tone_seq_pkg::*;

  localparam int TC = 4;
  localparam int GC = 2;

  typedef struct {
    logic [NUM_TONES-1:0] tone;
    logic                 busy;
    logic                 done;
  } exp_t;

  typedef struct {
    string       name;
    logic        play;
    logic        key;
    logic        mid_key;     // extra key strobe while busy, must be ignored
    logic [3:0]  kdig;
    logic [15:0] pdigs;
    logic [15:0] exp_codes;   // digits expected to play, slot 0 in [15:12]
    int          exp_len;
  } req_t;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];
  req_t tbl[7];

  piezo_tone_seq_if bus ();

  piezo_tone_seq #(
    .TONE_CYCLES (TC),
    .GAP_CYCLES  (GC),
    .CNT_W       (18)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NUM_TONES-1:0] oh(input logic [3:0] code);
    logic [NUM_TONES-1:0] r;
    r = '0;
    if (code <= 4'd9) r = 10'b1 << code;
    return r;
  endfunction

  function automatic void push(input logic [NUM_TONES-1:0] t, input logic b, input logic d,
                               input int n);
    exp_t e;
    e.tone = t; e.busy = b; e.done = d;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endfunction

  // Idle cycle before acceptance, tones and gaps, done cycle, one idle cycle.
  function automatic void push_trace(input logic [15:0] codes, input int len);
    push('0, 1'b0, 1'b0, 1);
    for (int i = 0; i < len; i++) begin
      push(oh(codes[15 - 4*i -: 4]), 1'b1, 1'b0, TC);
      if (i < len - 1) push('0, 1'b1, 1'b0, GC);
    end
    push('0, 1'b0, 1'b1, 1);
    push('0, 1'b0, 1'b0, 1);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("tone_en", 32'(bus.tone_en), 32'(e.tone));
      check("busy",    32'(bus.busy),    32'(e.busy));
      check("done",    32'(bus.done),    32'(e.done));
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_req(input req_t r);
    @(posedge clk); #1;
    bus.play_start  = r.play;
    bus.key_valid   = r.key;
    bus.key_digit   = r.kdig;
    bus.play_digits = r.pdigs;
    push_trace(r.exp_codes, r.exp_len);
    @(posedge clk); #1;
    bus.play_start  = 1'b0;
    bus.key_valid   = 1'b0;
    // Request data is latched; scrambling it now must not matter.
    bus.play_digits = ~r.pdigs;
    bus.key_digit   = ~r.kdig;
    if (r.mid_key) begin
      repeat (3) @(posedge clk);
      #1 bus.key_valid = 1'b1; bus.key_digit = 4'd2;
      @(posedge clk);
      #1 bus.key_valid = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    tbl[0] = '{"beep7",     1'b0, 1'b1, 1'b0, 4'd7,  16'h0000, 16'h7000, 1};
    tbl[1] = '{"play1234",  1'b1, 1'b0, 1'b0, 4'd0,  16'h1234, 16'h1234, 4};
    tbl[2] = '{"collision", 1'b1, 1'b1, 1'b1, 4'd9,  16'h5555, 16'h5555, 4};
    tbl[3] = '{"invalid",   1'b1, 1'b0, 1'b0, 4'd0,  16'h1A23, 16'h1A23, 4};
    tbl[4] = '{"beep0",     1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 16'h0000, 1};
    tbl[5] = '{"beep_bad",  1'b0, 1'b1, 1'b0, 4'd12, 16'h0000, 16'hC000, 1};
    tbl[6] = '{"play9087",  1'b1, 1'b0, 1'b0, 4'd0,  16'h9087, 16'h9087, 4};

    rst = 1'b0;
    bus.key_valid = 1'b0; bus.key_digit = '0;
    bus.play_start = 1'b0; bus.play_digits = '0; bus.abort = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tone_en", 32'(bus.tone_en), 0);
    check("rst_busy",    32'(bus.busy),    0);
    check("rst_done",    32'(bus.done),    0);
    #3 rst = 1'b1;

    for (int i = 0; i < 7; i++) run_req(tbl[i]);

    // Abort on the 2nd cycle of the second tone, then a normal beep.
    @(posedge clk); #1;
    bus.play_start = 1'b1; bus.play_digits = 16'h1234;
    push('0, 1'b0, 1'b0, 1);
    push(10'h002, 1'b1, 1'b0, TC);
    push('0, 1'b1, 1'b0, GC);
    push(10'h004, 1'b1, 1'b0, 2);
    push('0, 1'b0, 1'b0, 3);
    @(posedge clk); #1;
    bus.play_start = 1'b0;
    repeat (7) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    wait_drain();
    run_req('{"beep_after_abort", 1'b0, 1'b1, 1'b0, 4'd3, 16'h0000, 16'h3000, 1});

    // Abort in IDLE beats a simultaneous play_start.
    @(posedge clk); #1;
    bus.abort = 1'b1; bus.play_start = 1'b1; bus.play_digits = 16'h1234;
    push('0, 1'b0, 1'b0, 3);
    @(posedge clk); #1;
    bus.abort = 1'b0; bus.play_start = 1'b0;
    wait_drain();

    // Asynchronous reset in the first gap, released mid-cycle.
    @(posedge clk); #1;
    bus.play_start = 1'b1; bus.play_digits = 16'h1234;
    push('0, 1'b0, 1'b0, 1);
    push(10'h002, 1'b1, 1'b0, TC);
    @(posedge clk); #1;
    bus.play_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("gap_busy", 32'(bus.busy), 1);
    #1 rst = 1'b0;
    #1;
    check("arst_tone_en", 32'(bus.tone_en), 0);
    check("arst_busy",    32'(bus.busy),    0);
    check("arst_done",    32'(bus.done),    0);
    push('0, 1'b0, 1'b0, 3);
    repeat (2) @(posedge clk);
    #7 rst = 1'b1;
    wait_drain();
    run_req('{"play_after_rst", 1'b1, 1'b0, 1'b0, 4'd0, 16'h1234, 16'h1234, 4});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/piezo_tone_seq.md
Name: piezo_tone_seq

Overview:
Upstream driver of the piezo tone bank. Converts game events into the one-hot per-digit enables that the tone dividers consume (bit k enables the digit-k tone).
- Two request types: a single-key beep (one digit), or playback of a 4-digit BCD guess/answer, one tone per digit with silent gaps between tones.
- Guarantees at most one enable bit high at any time, so the OR-combined piezo output never mixes tones.

Parameters:
TONE_CYCLES, 200000, clk cycles each digit tone is held (min 1)
GAP_CYCLES, 50000, clk cycles of silence between consecutive digits in playback (min 1)
CNT_W, 18, duration counter width; must satisfy 2^CNT_W > max(TONE_CYCLES, GAP_CYCLES)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
key_valid  in  1  single-cycle strobe: beep digit key_digit
key_digit  in  4  BCD digit for the beep
play_start  in  1  single-cycle strobe: play play_digits
play_digits  in  16  four BCD digits; [15:12] played first, [3:0] last
abort  in  1  synchronous stop; silences output immediately
tone_en  out  10  one-hot tone enables; bit k drives the digit-k tone
busy  out  1  high while a beep or playback is in progress
done  out  1  one-cycle pulse when a request completes normally

Behaviour:
- Reset (rst low, asynchronous): state IDLE; tone_en=0, busy=0, done=0, counter=0, digit index=0.
- States: IDLE, TONE, GAP.
- IDLE:
  - play_start=1 at edge n: latch play_digits, index=0, go to TONE.
  - Else key_valid=1 at edge n: latch key_digit as a 1-digit sequence, go to TONE.
  - Both strobes high in the same cycle: play_start wins; key_valid is dropped.
- TONE:
  - tone_en = one-hot of the current digit, registered. It is high from cycle n+1 for exactly TONE_CYCLES cycles.
  - Not the last digit: go to GAP.
  - Last digit: go to IDLE and pulse done=1 in the first IDLE cycle. No trailing gap.
- GAP: tone_en=0 for exactly GAP_CYCLES cycles; index+1; return to TONE.
- Digit code >9 (10..15): that slot keeps its full TONE_CYCLES timing, but tone_en=0 throughout.
- busy=1 in TONE and GAP; 0 in IDLE. It goes low in the same cycle done pulses.
- key_valid and play_start arriving while busy=1 are ignored and not queued.
- abort=1 at any edge:
  - Next cycle: IDLE, tone_en=0, busy=0, done=0.
  - abort has priority over a simultaneous start strobe.
  - abort in IDLE has no effect.
- play_digits and key_digit are sampled only on the accepting edge; later changes have no effect on the request in progress.
- Counter: loads 0 on each state entry and compares against PARAM-1. It never wraps within a valid configuration.
- tone_en is driven directly from a register (glitch-free); at most one bit is ever set.

Decomposition:
- Shared package: NUM_TONES=10, SEQ_LEN=4, BCD_W=4, state enum (IDLE/TONE/GAP).
- Sub-module bcd_onehot_dec: 4-bit code in, 10-bit one-hot out. Outputs all zeros for codes >9. Reused wherever digits drive LEDs or tones.

Test Plan:
(All with TONE_CYCLES=4, GAP_CYCLES=2.)
1. Beep: key_valid=1, key_digit=7 in IDLE.
   -> tone_en=10'b0010000000 for 4 cycles, then 0.
   -> done pulses once; busy high for exactly 4 cycles.
2. Playback: play_digits=16'h1234.
   -> tone_en sequence 0x002 x4, 0 x2, 0x004 x4, 0 x2, 0x008 x4, 0 x2, 0x010 x4, then 0.
   -> done 1 cycle after the last tone; 22 busy cycles in total.
3. Collision: play_start and key_valid (digit 9) in the same cycle, play_digits=16'h5555.
   -> playback of four digit-5 tones only.
   -> A key_valid arriving mid-playback produces no extra tone.
4. Invalid digit: play_digits=16'h1A23.
   -> second slot silent for 4 cycles, timing unchanged (22 busy cycles).
   -> done pulses normally.
5. Abort: abort asserted on the 2nd cycle of the second tone.
   -> next cycle tone_en=0, busy=0, no done pulse.
   -> A subsequent beep request is accepted normally.
6. Async reset: rst low mid-GAP, released mid-cycle.
   -> all outputs 0 immediately on assertion.
   -> IDLE after release; play_start then plays from digit [15:12].
